// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, takes exceptions/eret at mem,
// and drives flush, the CP0 update and a held PC redirect handshake.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_stall_req,
  input  logic        i_id_stall_req,
  input  logic        i_ex_stall_req,
  input  logic        i_mem_stall_req,
  input  logic        i_exc_valid,
  input  logic [4:0]  i_excode,
  input  logic        i_eret,
  input  logic [31:0] i_mem_pc,
  input  logic        i_mem_bd,
  input  logic [31:0] i_cp0_epc,
  input  logic        i_redirect_ack,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_cp0_exc_we,
  output logic        o_cp0_eret,
  output logic [31:0] o_cp0_epc,
  output logic [4:0]  o_cp0_excode,
  output logic        o_cp0_bd
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state;
  logic [31:0] pending_pc;
  logic        take;
  logic [31:0] take_target;

  // A stalled mem stage keeps its event until the access completes.
  assign take        = (state == RUN) & (i_exc_valid | i_eret) & ~i_mem_stall_req;
  assign take_target = i_exc_valid ? EXC_VECTOR : i_cp0_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      pending_pc <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (take && !i_redirect_ack) begin
            state      <= REDIRECT;
            pending_pc <= take_target;
          end
        end
        REDIRECT: begin
          if (i_redirect_ack) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Outputs respond in the take cycle itself, and are forced low while reset is held.
  always_comb begin
    o_stall          = 6'b000000;
    o_flush          = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'd0;
    o_cp0_exc_we     = 1'b0;
    o_cp0_eret       = 1'b0;
    o_cp0_epc        = 32'd0;
    o_cp0_excode     = 5'd0;
    o_cp0_bd         = 1'b0;
    if (reset) begin
      if (state == REDIRECT) begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = pending_pc;
      end else if (take) begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = take_target;
        if (i_exc_valid) begin
          o_cp0_exc_we = 1'b1;
          o_cp0_excode = i_excode;
          o_cp0_bd     = i_mem_bd;
          o_cp0_epc    = i_mem_bd ? (i_mem_pc - 32'd4) : i_mem_pc;
        end else begin
          o_cp0_eret = 1'b1;
        end
      end else if (i_mem_stall_req) begin
        o_stall = 6'b011111;
      end else if (i_ex_stall_req) begin
        o_stall = 6'b001111;
      end else if (i_id_stall_req) begin
        o_stall = 6'b000111;
      end else if (i_if_stall_req) begin
        o_stall = 6'b000011;
      end
    end
  end

endmodule
